// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and sign fix-up helper for muldiv_multi.
package muldiv_pkg;
    localparam int MAX_W = 128;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ITER,
        S_SPECIAL,
        S_FIX,
        S_DONE
    } muldiv_state_e;

    // Wide enough for a 2*XLEN product with XLEN up to 64; callers truncate.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] value, input logic neg);
        return neg ? -value : value;
    endfunction
endpackage

// File: rtl/muldiv_multi.sv
// muldiv_multi: iterative RV32M/RV64M multiply/divide, one bit per cycle on magnitudes then sign fix-up.
// MULDIV_EARLY_OUT_EN: multiplies leave ITER once the remaining multiplier bits are all zero.
module muldiv_multi
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = '1;

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d, op_in;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, x_q, x_d, prod_fix;
    logic [XLEN-1:0]   y_q, y_d, result_q, result_d;
    logic [XLEN-1:0]   mag_a, mag_b, spec_val, fix_val;
    logic [XLEN:0]     rem_sh, diff;
    logic              sa, sb, b_zero, ovf, mul_last;

    always_comb begin
        op_in    = muldiv_op_e'(funct3);
        sa       = a[XLEN-1] && (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sb       = b[XLEN-1] && (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;
        b_zero   = b == '0;
        ovf      = a == MIN && b == ONES && (op_in inside {OP_DIV, OP_REM});
        spec_val = op_in[1] ? (b_zero ? a : '0) : (b_zero ? ONES : a);
        // x_q holds the divisor, acc_q[XLEN:0] the partial remainder, y_q dividend/quotient
        rem_sh   = {acc_q[XLEN-1:0], y_q[XLEN-1]};
        diff     = rem_sh - {1'b0, x_q[XLEN-1:0]};
`ifdef MULDIV_EARLY_OUT_EN
        mul_last = !op_q[2] && y_q[XLEN-1:1] == '0;
`else
        mul_last = 1'b0;
`endif
        prod_fix = (2*XLEN)'(cond_neg(MAX_W'(acc_q), neg_q));
        fix_val  = op_q == OP_MUL ? prod_fix[XLEN-1:0] :
                   !op_q[2]       ? prod_fix[2*XLEN-1:XLEN] :
                   XLEN'(cond_neg(MAX_W'(op_q[1] ? acc_q[XLEN-1:0] : y_q), neg_q));
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op_in;
                    neg_d = op_in == OP_REM ? sa : sa ^ sb;
                    cnt_d = '0;
                    if (op_in[2] && (b_zero || ovf)) begin
                        state_d = S_SPECIAL;
                        acc_d   = (2*XLEN)'(spec_val);
                    end else begin
                        state_d = S_ITER;
                        acc_d   = '0;
                        x_d     = (2*XLEN)'(op_in[2] ? mag_b : mag_a);
                        y_d     = op_in[2] ? mag_a : mag_b;
                    end
                end
            end
            S_ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (!op_q[2]) begin
                    acc_d = acc_q + (y_q[0] ? x_q : '0);
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                end else begin
                    acc_d = (2*XLEN)'(diff[XLEN] ? rem_sh : diff);
                    y_d   = {y_q[XLEN-2:0], !diff[XLEN]};
                end
                if (cnt_q == CW'(XLEN-1) || mul_last)
                    state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_val;
                state_d  = S_DONE;
            end
            S_SPECIAL: begin
                result_d = acc_q[XLEN-1:0];
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
        end
    end

    assign busy   = state_q != S_IDLE;
    assign done   = state_q == S_DONE;
    assign result = result_q;
endmodule
